l1_l2_arbiter: RTL and testbench

//  Shares the single L2 request port between the L1_I and L1_D controllers.

---
 rtl/l1_l2_arbiter.sv | 169 ++++++++++++++++
 tb/tb_l1_l2_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter sharing one L2 request port between the L1_I and L1_D controllers.
// Single transaction in flight: IDLE -> BUSY (L2 owns the request) -> RESP (done pulse) -> GAP.
//
// Handshake: a requester holds its request level until it sees its 1-cycle
// ready_L2_x pulse. The L2 side sees a registered read/write level plus a
// stable tag/index/data for the whole BUSY phase and ends it with ready_L2_L1.
module l1_l2_arbiter #(
  parameter int TNUM_2 = 18,
  parameter int INUM_2 = 8,
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_I_L2,
  input  logic [TNUM_2-1:0] tag_I_L2,
  input  logic [INUM_2-1:0] index_I_L2,
  output logic              ready_L2_I,
  output logic [DATA_W-1:0] data_L2_I,
  input  logic              read_D_L2,
  input  logic              write_D_L2,
  input  logic [TNUM_2-1:0] tag_D_L2,
  input  logic [INUM_2-1:0] index_D_L2,
  input  logic [DATA_W-1:0] data_D_L2,
  output logic              ready_L2_D,
  output logic [DATA_W-1:0] data_L2_D,
  output logic              read_L1_L2,
  output logic              write_L1_L2,
  output logic [TNUM_2-1:0] tag_L1_L2,
  output logic [INUM_2-1:0] index_L1_L2,
  output logic [DATA_W-1:0] data_L1_L2,
  input  logic              ready_L2_L1,
  input  logic [DATA_W-1:0] data_L2_L1,
  output logic [1:0]        grant,
  output logic [1:0]        state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                last_d_q, last_d_d;   // 1: D won the previous arbitration
  logic [1:0]          grant_q, grant_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [TNUM_2-1:0]   tag_q, tag_d;
  logic [INUM_2-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rdy_i_q, rdy_i_d;
  logic                rdy_d_q, rdy_d_d;
  logic [DATA_W-1:0]   data_i_q, data_i_d;
  logic [DATA_W-1:0]   data_d_q, data_d_d;
  logic                req_i, req_d, pick_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      grant_q  <= 2'b00;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      tag_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdy_i_q  <= 1'b0;
      rdy_d_q  <= 1'b0;
      data_i_q <= '0;
      data_d_q <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      grant_q  <= grant_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdy_i_q  <= rdy_i_d;
      rdy_d_q  <= rdy_d_d;
      data_i_q <= data_i_d;
      data_d_q <= data_d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    grant_d  = grant_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    tag_d    = tag_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdy_i_d  = 1'b0;
    rdy_d_d  = 1'b0;
    data_i_d = data_i_q;
    data_d_d = data_d_q;
    req_i    = read_I_L2;
    req_d    = read_D_L2 | write_D_L2;
    // On a tie the side that did not win last time goes first.
    pick_d   = req_d & (~req_i | ~last_d_q);

    case (state_q)
      IDLE: begin
        if (req_i || req_d) begin
          state_d  = BUSY;
          last_d_d = pick_d;
          if (pick_d) begin
            grant_d = 2'b10;
            // read+write together is illegal; the write wins so dirty data is never lost.
            wr_d    = write_D_L2;
            rd_d    = read_D_L2 & ~write_D_L2;
            tag_d   = tag_D_L2;
            idx_d   = index_D_L2;
            wdata_d = write_D_L2 ? data_D_L2 : '0;
          end else begin
            grant_d = 2'b01;
            wr_d    = 1'b0;
            rd_d    = 1'b1;
            tag_d   = tag_I_L2;
            idx_d   = index_I_L2;
            wdata_d = '0;
          end
        end
      end
      BUSY: begin
        if (ready_L2_L1) begin
          state_d = RESP;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (grant_q[0]) begin
            rdy_i_d  = 1'b1;
            data_i_d = data_L2_L1;
          end else begin
            rdy_d_d  = 1'b1;
            data_d_d = data_L2_L1;
          end
        end
      end
      RESP: begin
        state_d = GAP;
        grant_d = 2'b00;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign ready_L2_I  = rdy_i_q;
  assign data_L2_I   = data_i_q;
  assign ready_L2_D  = rdy_d_q;
  assign data_L2_D   = data_d_q;
  assign read_L1_L2  = rd_q;
  assign write_L1_L2 = wr_q;
  assign tag_L1_L2   = tag_q;
  assign index_L1_L2 = idx_q;
  assign data_L1_L2  = wdata_q;
  assign grant       = grant_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Bench for l1_l2_arbiter: directed scenarios plus randomized rounds checked
// against a transaction-level model of the round-robin and response timing.
module tb_l1_l2_arbiter;

  localparam int TW = 18;
  localparam int IW = 8;
  localparam int DW = 512;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_I_L2;
  logic [TW-1:0] tag_I_L2;
  logic [IW-1:0] index_I_L2;
  logic          ready_L2_I;
  logic [DW-1:0] data_L2_I;
  logic          read_D_L2;
  logic          write_D_L2;
  logic [TW-1:0] tag_D_L2;
  logic [IW-1:0] index_D_L2;
  logic [DW-1:0] data_D_L2;
  logic          ready_L2_D;
  logic [DW-1:0] data_L2_D;
  logic          read_L1_L2;
  logic          write_L1_L2;
  logic [TW-1:0] tag_L1_L2;
  logic [IW-1:0] index_L1_L2;
  logic [DW-1:0] data_L1_L2;
  logic          ready_L2_L1;
  logic [DW-1:0] data_L2_L1;
  logic [1:0]    grant;
  logic [1:0]    state_dbg_o;

  // clock / reset block
  always #5 clk = ~clk;

  l1_l2_arbiter #(.TNUM_2(TW), .INUM_2(IW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .read_I_L2(read_I_L2), .tag_I_L2(tag_I_L2), .index_I_L2(index_I_L2),
    .ready_L2_I(ready_L2_I), .data_L2_I(data_L2_I),
    .read_D_L2(read_D_L2), .write_D_L2(write_D_L2), .tag_D_L2(tag_D_L2),
    .index_D_L2(index_D_L2), .data_D_L2(data_D_L2),
    .ready_L2_D(ready_L2_D), .data_L2_D(data_L2_D),
    .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2), .tag_L1_L2(tag_L1_L2),
    .index_L1_L2(index_L1_L2), .data_L1_L2(data_L1_L2),
    .ready_L2_L1(ready_L2_L1), .data_L2_L1(data_L2_L1),
    .grant(grant), .state_dbg_o(state_dbg_o)
  );

  // scoreboard state
  int            n_checks = 0;
  int            n_pass   = 0;
  int            served_i = 0;
  int            served_d = 0;
  bit            m_last_d;          // model: D won the previous arbitration
  logic [DW-1:0] m_data_i;          // model: last line returned to I
  logic [DW-1:0] m_data_d;          // model: last line returned to D
  logic [DW-1:0] exp_q[$];          // expected response lines, in grant order

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // driver tasks
  task automatic new_req_i();
    read_I_L2  = 1'b1;
    tag_I_L2   = TW'($urandom);
    index_I_L2 = IW'($urandom);
  endtask

  task automatic new_req_d();
    int op;
    op = $urandom_range(0, 19);
    read_D_L2  = (op < 9) || (op == 19);
    write_D_L2 = (op >= 9);
    tag_D_L2   = TW'($urandom);
    index_D_L2 = IW'($urandom);
    data_D_L2  = rand_line();
  endtask

  task automatic check_quiet(input string tag, input logic [1:0] st);
    check({tag, "_state"}, state_dbg_o, st);
    check({tag, "_grant"}, grant, 2'b00);
    check({tag, "_rdy"}, {ready_L2_I, ready_L2_D}, 2'b00);
    check({tag, "_l2req"}, {read_L1_L2, write_L1_L2}, 2'b00);
  endtask

  // One arbitration round starting with the DUT in IDLE.
  // scramble: 0 none, 1 loser payload, 2 winner payload during BUSY.
  // refill:   0 winner drops, 1 winner re-requests, 2 random.
  task automatic do_round(input string tag, input int delay, input int scramble, input int refill);
    int            w;
    bit            ri, rd, e_rd, e_wr;
    logic [TW-1:0] e_tag;
    logic [IW-1:0] e_idx;
    logic [DW-1:0] e_dat, line;
    ri = read_I_L2;
    rd = read_D_L2 | write_D_L2;
    if (!ri && !rd) begin
      tick();
      check_quiet({tag, "_idle"}, S_IDLE);
      return;
    end
    if (ri && rd) w = m_last_d ? 0 : 1;
    else          w = ri ? 0 : 1;
    if (w == 0) begin
      e_rd = 1'b1; e_wr = 1'b0; e_tag = tag_I_L2; e_idx = index_I_L2; e_dat = '0;
    end else begin
      if (read_D_L2 && write_D_L2)
        $display("note: illegal read_D_L2&write_D_L2 driven, expecting a write (t=%0t)", $time);
      e_wr  = write_D_L2;
      e_rd  = !write_D_L2;
      e_tag = tag_D_L2;
      e_idx = index_D_L2;
      e_dat = write_D_L2 ? data_D_L2 : '0;
    end
    m_last_d = (w == 1);

    tick();
    check({tag, "_grant"}, grant, (w == 0) ? 2'b01 : 2'b10);
    check({tag, "_state_busy"}, state_dbg_o, S_BUSY);
    check({tag, "_rdwr"}, {read_L1_L2, write_L1_L2}, {e_rd, e_wr});
    check({tag, "_tag"}, tag_L1_L2, e_tag);
    check({tag, "_idx"}, index_L1_L2, e_idx);
    check({tag, "_wdata"}, data_L1_L2, e_dat);

    for (int b = 0; b < delay; b++) begin
      if ((scramble == 1 && w == 0) || (scramble == 2 && w == 1)) begin
        tag_D_L2 = TW'($urandom); index_D_L2 = IW'($urandom); data_D_L2 = rand_line();
      end
      if ((scramble == 1 && w == 1) || (scramble == 2 && w == 0)) begin
        tag_I_L2 = TW'($urandom); index_I_L2 = IW'($urandom);
      end
      ready_L2_L1 = 1'b0;
      data_L2_L1  = rand_line();
      tick();
      check({tag, "_busy_state"}, state_dbg_o, S_BUSY);
      check({tag, "_busy_hold"}, {read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2},
            {e_rd, e_wr, e_tag, e_idx});
      check({tag, "_busy_wdata"}, data_L1_L2, e_dat);
      check({tag, "_busy_rdy"}, {ready_L2_I, ready_L2_D}, 2'b00);
    end

    line = rand_line();
    exp_q.push_back(line);
    ready_L2_L1 = 1'b1;
    data_L2_L1  = line;
    tick();
    ready_L2_L1 = 1'b0;
    line = exp_q.pop_front();
    if (w == 0) begin m_data_i = line; served_i++; end
    else        begin m_data_d = line; served_d++; end
    check({tag, "_resp_state"}, state_dbg_o, S_RESP);
    check({tag, "_resp_grant"}, grant, (w == 0) ? 2'b01 : 2'b10);
    check({tag, "_resp_rdy"}, {ready_L2_I, ready_L2_D}, (w == 0) ? 2'b10 : 2'b01);
    check({tag, "_resp_l2req"}, {read_L1_L2, write_L1_L2}, 2'b00);
    check({tag, "_data_i"}, data_L2_I, m_data_i);
    check({tag, "_data_d"}, data_L2_D, m_data_d);

    // Winner drops or replaces its request; a stray L2 ready must be ignored.
    if (refill == 1 || (refill == 2 && $urandom_range(0, 1) == 1)) begin
      if (w == 0) new_req_i(); else new_req_d();
    end else begin
      if (w == 0) read_I_L2 = 1'b0;
      else begin read_D_L2 = 1'b0; write_D_L2 = 1'b0; end
    end
    ready_L2_L1 = 1'($urandom_range(0, 1));
    data_L2_L1  = rand_line();
    tick();
    check_quiet({tag, "_gap"}, S_GAP);
    check({tag, "_gap_data_i"}, data_L2_I, m_data_i);
    check({tag, "_gap_data_d"}, data_L2_D, m_data_d);

    ready_L2_L1 = 1'($urandom_range(0, 1));
    tick();
    ready_L2_L1 = 1'b0;
    check_quiet({tag, "_back_idle"}, S_IDLE);
  endtask

  task automatic clear_reqs();
    read_I_L2 = 1'b0; read_D_L2 = 1'b0; write_D_L2 = 1'b0;
  endtask

  initial begin
    int si, sd;
    rst = 1'b1;
    clear_reqs();
    tag_I_L2 = '0; index_I_L2 = '0;
    tag_D_L2 = '0; index_D_L2 = '0; data_D_L2 = '0;
    ready_L2_L1 = 1'b0; data_L2_L1 = '0;
    m_last_d = 1'b1; m_data_i = '0; m_data_d = '0;
    repeat (3) tick();
    check_quiet("reset", S_IDLE);
    check("reset_data", {data_L2_I, data_L2_D, data_L1_L2, tag_L1_L2, index_L1_L2}, '0);
    rst = 1'b0;

    // T2: simultaneous reads after reset -> I then D, one pulse each
    read_I_L2 = 1'b1; tag_I_L2 = 18'h01111; index_I_L2 = 8'h11;
    read_D_L2 = 1'b1; tag_D_L2 = 18'h02222; index_D_L2 = 8'h22;
    do_round("t2_i", 2, 0, 0);
    check("t2_i_first", served_i, 1);
    do_round("t2_d", 1, 0, 0);
    check("t2_d_second", served_d, 1);

    // T3: D write-back queued behind I; D payload toggled during its own BUSY
    read_I_L2 = 1'b1; tag_I_L2 = 18'h00abc; index_I_L2 = 8'h5c;
    write_D_L2 = 1'b1; tag_D_L2 = 18'h3c0de; index_D_L2 = 8'hd0; data_D_L2 = {64{8'hA5}};
    do_round("t3_i", 3, 0, 0);
    do_round("t3_d", 4, 2, 0);

    // T1: I-only read, L2 answers 4 cycles into BUSY
    clear_reqs();
    read_I_L2 = 1'b1; tag_I_L2 = 18'h2A5B1; index_I_L2 = 8'h13;
    do_round("t1", 4, 0, 0);

    // T5: stray L2 ready while idle
    clear_reqs();
    ready_L2_L1 = 1'b1;
    do_round("t5", 0, 0, 0);
    do_round("t5b", 0, 0, 0);
    ready_L2_L1 = 1'b0;

    // T4: both sides held for 8 transactions -> strict alternation
    new_req_i();
    new_req_d();
    si = served_i; sd = served_d;
    for (int k = 0; k < 8; k++) do_round("t4", $urandom_range(0, 3), 1, 1);
    check("t4_share_i", served_i - si, 4);
    check("t4_share_d", served_d - sd, 4);

    // Randomized rounds
    clear_reqs();
    for (int k = 0; k < 120; k++) begin
      if (!read_I_L2 && $urandom_range(0, 2) != 0) new_req_i();
      if (!read_D_L2 && !write_D_L2 && $urandom_range(0, 2) != 0) new_req_d();
      do_round("rnd", $urandom_range(0, 4), $urandom_range(0, 1), 2);
    end

    // T6: reset in the middle of BUSY, then a tie must go to I
    clear_reqs();
    tick();
    new_req_i();
    read_D_L2 = 1'b1; write_D_L2 = 1'b0;
    tick();
    check("t6_pre_busy", state_dbg_o, S_BUSY);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("t6_rst", S_IDLE);
    check("t6_rst_data", {data_L2_I, data_L2_D, data_L1_L2, tag_L1_L2, index_L1_L2}, '0);
    m_last_d = 1'b1; m_data_i = '0; m_data_d = '0;
    si = served_i;
    do_round("t6_tie", 1, 0, 0);
    check("t6_tie_to_i", served_i - si, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
